// File: rtl/commit_wport_arbiter_if.sv
// Request/write-port bundle between the commit requesters, the arbiter and the commit queue.
// master = requester and queue side, slave = arbiter.
interface commit_wport_arbiter_if #(
   parameter int NREQ   = 4,
   parameter int WPORTS = 2,
   parameter int DW     = 64
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*DW-1:0]   req_data;
   logic [NREQ-1:0]      req_ready;
   logic [WPORTS-1:0]    wr_valid;
   logic [WPORTS*DW-1:0] wr_data;
   logic                 q_pop;

   modport master (
      output req_valid,
      output req_data,
      output q_pop,
      input  req_ready,
      input  wr_valid,
      input  wr_data
   );

   modport slave (
      input  req_valid,
      input  req_data,
      input  q_pop,
      output req_ready,
      output wr_valid,
      output wr_data
   );
endinterface

// File: rtl/commit_wport_arbiter.sv
// Round-robin, credit-limited arbiter packing up to WPORTS commit requests per cycle onto queue write ports.
// Optional COMMIT_ARB_STATS_EN adds stall and per-requester grant counters.
module commit_wport_arbiter #(
   parameter int NREQ   = 4,
   parameter int WPORTS = 2,
   parameter int QLEN   = 16,
   parameter int DW     = 64,
   localparam int CW    = $clog2(QLEN) + 1,
   localparam int PW    = $clog2(NREQ)
) (
   input  logic                   clk,
   input  logic                   reset,
   commit_wport_arbiter_if.slave  bus,
   output logic [CW-1:0]          credits,
   output logic                   full
`ifdef COMMIT_ARB_STATS_EN
   ,
   output logic [31:0]            stall_cycles,
   output logic [NREQ*32-1:0]     grant_cnt
`endif
);

   localparam logic [CW-1:0] QLEN_C = CW'(QLEN);
   localparam logic [CW-1:0] WP_C   = CW'(WPORTS);
   localparam logic [CW:0]   QLEN_X = (CW+1)'(QLEN);

   logic [PW-1:0]        rr_ptr;
   logic [PW-1:0]        last_idx;
   logic [PW-1:0]        idx;
   logic [CW-1:0]        limit;
   logic [CW-1:0]        ngrant;
   logic [CW:0]          credit_sum;
   logic [CW-1:0]        credits_next;
   logic [NREQ-1:0]      grant;
   logic [WPORTS-1:0]    port_valid;
   logic [WPORTS*DW-1:0] pack_data;
   logic [WPORTS-1:0]    wr_valid_q;
   logic [WPORTS*DW-1:0] wr_data_q;

   // Grants are bounded by the registered credit count, so a pop only helps next cycle.
   always_comb begin
      limit      = (credits < WP_C) ? credits : WP_C;
      grant      = '0;
      ngrant     = '0;
      last_idx   = rr_ptr;
      idx        = '0;
      pack_data  = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = rr_ptr + PW'(k);
         if (bus.req_valid[idx] && (ngrant < limit)) begin
            grant[idx] = 1'b1;
            for (int p = 0; p < WPORTS; p++) begin
               if (ngrant == CW'(p)) begin
                  pack_data[p*DW +: DW] = bus.req_data[idx*DW +: DW];
               end
            end
            last_idx = idx;
            ngrant   = ngrant + 1'b1;
         end
      end
   end

   always_comb begin
      port_valid = '0;
      for (int p = 0; p < WPORTS; p++) begin
         port_valid[p] = (CW'(p) < ngrant);
      end
   end

   // ngrant <= credits, so the subtraction cannot underflow; only a pop at QLEN needs clamping.
   always_comb begin
      credit_sum = {1'b0, credits} - {1'b0, ngrant} + {{CW{1'b0}}, bus.q_pop};
      if (credit_sum > QLEN_X) begin
         credits_next = QLEN_C;
      end else begin
         credits_next = credit_sum[CW-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         credits    <= QLEN_C;
         rr_ptr     <= '0;
         wr_valid_q <= '0;
         wr_data_q  <= '0;
      end else begin
         credits    <= credits_next;
         wr_valid_q <= port_valid;
         if (ngrant != '0) begin
            rr_ptr <= last_idx + 1'b1;
         end
         for (int p = 0; p < WPORTS; p++) begin
            if (port_valid[p]) begin
               wr_data_q[p*DW +: DW] <= pack_data[p*DW +: DW];
            end
         end
      end
   end

   assign bus.req_ready = grant;
   assign bus.wr_valid  = wr_valid_q;
   assign bus.wr_data   = wr_data_q;
   assign full          = (credits == '0);

`ifdef COMMIT_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
         grant_cnt    <= '0;
      end else begin
         if ((|bus.req_valid) && (credits == '0)) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
         for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
               grant_cnt[i*32 +: 32] <= grant_cnt[i*32 +: 32] + 32'd1;
            end
         end
      end
   end
`endif

`ifndef SYNTHESIS
   // A pop with every slot already free means the consumer and the credit count disagree.
   pop_at_full_credit: assert property (@(posedge clk) disable iff (reset)
      !(bus.q_pop && (credits == QLEN_C)));
`endif

endmodule
